// File: rtl/recorder_event_decoder_if.sv
// Event/command bundle between the input controller, the recorder core and
// the event decoder; the decoder uses the slave modport.
interface recorder_event_decoder_if;
  logic [15:0] i_input_event;
  logic        i_play_done;
  logic        i_rec_full;
  logic        i_cmd_ready;
  logic        o_cmd_valid;
  logic [2:0]  o_cmd;
  logic [2:0]  o_state;
  logic [1:0]  o_speed_mode;
  logic [3:0]  o_speed_factor;
  logic        o_interpol;
  logic        o_err;

  modport slave (
    input  i_input_event, i_play_done, i_rec_full, i_cmd_ready,
    output o_cmd_valid, o_cmd, o_state, o_speed_mode, o_speed_factor,
           o_interpol, o_err
  );

  modport master (
    output i_input_event, i_play_done, i_rec_full, i_cmd_ready,
    input  o_cmd_valid, o_cmd, o_state, o_speed_mode, o_speed_factor,
           o_interpol, o_err
  );
endinterface

// File: rtl/recorder_event_decoder.sv
// Decodes input-event words, runs the recorder transport FSM, and issues one
// transport command at a time to the recorder core over valid/ready.
module recorder_event_decoder #(
  parameter int unsigned MAX_FACTOR = 8
) (
  input logic                       i_clk,
  input logic                       i_rst,
  recorder_event_decoder_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PLAY        = 3'd1,
    PLAY_PAUSED = 3'd2,
    REC         = 3'd3,
    REC_PAUSED  = 3'd4
  } state_t;

  localparam logic [3:0] EV_NONE   = 4'd0;
  localparam logic [3:0] EV_PLAY   = 4'd1;
  localparam logic [3:0] EV_PAUSE  = 4'd2;
  localparam logic [3:0] EV_STOP   = 4'd3;
  localparam logic [3:0] EV_RECORD = 4'd4;
  localparam logic [3:0] EV_SPEED  = 4'd5;

  localparam logic [2:0] CMD_NONE       = 3'd0;
  localparam logic [2:0] CMD_START_PLAY = 3'd1;
  localparam logic [2:0] CMD_PAUSE      = 3'd2;
  localparam logic [2:0] CMD_RESUME     = 3'd3;
  localparam logic [2:0] CMD_STOP       = 3'd4;
  localparam logic [2:0] CMD_START_REC  = 3'd5;

  localparam logic [3:0] FACTOR_MAX = 4'(MAX_FACTOR);

  state_t     state;
  logic [3:0] code;
  logic [1:0] mode;
  logic [3:0] param;
  logic       interp_bit;
  logic       free;
  logic       done;
  logic [3:0] sat_factor;
  state_t     t_next;
  logic [2:0] t_cmd;
  logic       t_err;

  assign code       = bus.i_input_event[15:12];
  assign mode       = bus.i_input_event[11:10];
  assign param      = bus.i_input_event[9:6];
  assign interp_bit = bus.i_input_event[5];
  assign bus.o_state = state;

  // A command accepted this cycle frees the core for a new one on the same edge
  assign free = !bus.o_cmd_valid || bus.i_cmd_ready;
  assign done = ((state == PLAY || state == PLAY_PAUSED) && bus.i_play_done) ||
                ((state == REC  || state == REC_PAUSED)  && bus.i_rec_full);

  always_comb begin
    sat_factor = param;
    if (param == 4'd0)
      sat_factor = 4'd1;
    else if (param > FACTOR_MAX)
      sat_factor = FACTOR_MAX;
  end

  // Transport table: t_cmd == CMD_NONE with t_err == 0 means the event is ignored
  always_comb begin
    t_next = state;
    t_cmd  = CMD_NONE;
    t_err  = 1'b0;
    case (state)
      IDLE: begin
        if (code == EV_PLAY) begin t_next = PLAY; t_cmd = CMD_START_PLAY; end
        else if (code == EV_RECORD) begin t_next = REC; t_cmd = CMD_START_REC; end
        else t_err = 1'b1;
      end
      PLAY: begin
        if (code == EV_PAUSE) begin t_next = PLAY_PAUSED; t_cmd = CMD_PAUSE; end
        else if (code == EV_STOP) begin t_next = IDLE; t_cmd = CMD_STOP; end
        else if (code == EV_RECORD) t_err = 1'b1;
      end
      PLAY_PAUSED: begin
        if (code == EV_PLAY) begin t_next = PLAY; t_cmd = CMD_RESUME; end
        else if (code == EV_STOP) begin t_next = IDLE; t_cmd = CMD_STOP; end
        else if (code == EV_RECORD) t_err = 1'b1;
      end
      REC: begin
        if (code == EV_PAUSE) begin t_next = REC_PAUSED; t_cmd = CMD_PAUSE; end
        else if (code == EV_STOP) begin t_next = IDLE; t_cmd = CMD_STOP; end
        else if (code == EV_PLAY) t_err = 1'b1;
      end
      REC_PAUSED: begin
        if (code == EV_RECORD) begin t_next = REC; t_cmd = CMD_RESUME; end
        else if (code == EV_STOP) begin t_next = IDLE; t_cmd = CMD_STOP; end
        else if (code == EV_PLAY) t_err = 1'b1;
      end
      default: t_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state              <= IDLE;
      bus.o_cmd_valid    <= 1'b0;
      bus.o_cmd          <= CMD_NONE;
      bus.o_speed_mode   <= 2'b00;
      bus.o_speed_factor <= 4'd1;
      bus.o_interpol     <= 1'b0;
      bus.o_err          <= 1'b0;
    end else begin
      bus.o_err <= 1'b0;
      if (bus.o_cmd_valid && bus.i_cmd_ready)
        bus.o_cmd_valid <= 1'b0;
      // Core completion wins over any same-cycle event, which is dropped silently
      if (done) begin
        state           <= IDLE;
        bus.o_cmd_valid <= 1'b0;
      end else if (code == EV_SPEED) begin
        if (state == REC || state == REC_PAUSED || mode == 2'b11) begin
          bus.o_err <= 1'b1;
        end else begin
          bus.o_speed_mode   <= mode;
          bus.o_speed_factor <= (mode == 2'b00) ? 4'd1 : sat_factor;
          bus.o_interpol     <= (mode == 2'b10) && interp_bit;
        end
      end else if (code >= EV_PLAY && code <= EV_RECORD) begin
        if (!free || t_err) begin
          bus.o_err <= 1'b1;
        end else if (t_cmd != CMD_NONE) begin
          state           <= t_next;
          bus.o_cmd_valid <= 1'b1;
          bus.o_cmd       <= t_cmd;
          if (t_cmd == CMD_START_REC) begin
            bus.o_speed_mode   <= 2'b00;
            bus.o_speed_factor <= 4'd1;
            bus.o_interpol     <= 1'b0;
          end
        end
      end else if (code != EV_NONE) begin
        bus.o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_recorder_event_decoder.sv
// Self-checking bench for recorder_event_decoder: directed scenarios plus a
// randomized run, all compared against a table-driven behavioural model.
module tb_recorder_event_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  recorder_event_decoder_if bus ();

  recorder_event_decoder #(.MAX_FACTOR(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_state, m_cmd, m_mode, m_factor;
  bit m_valid, m_interp, m_err;
  int  tr_next [5][5];
  int  tr_cmd  [5][5];
  bit  tr_err  [5][5];

  localparam logic [14:0] RESET_VEC = {3'd0, 1'b0, 3'd0, 2'd0, 4'd1, 1'b0, 1'b0};

  logic [14:0] obs;
  assign obs = {bus.o_state, bus.o_cmd_valid, bus.o_cmd, bus.o_speed_mode,
                bus.o_speed_factor, bus.o_interpol, bus.o_err};

  function automatic logic [14:0] expv();
    return {3'(m_state), m_valid, 3'(m_cmd), 2'(m_mode), 4'(m_factor), m_interp, m_err};
  endfunction

  function automatic logic [15:0] mk_ev(int code, int mode, int param, bit ip);
    logic [4:0] junk;
    junk = 5'($urandom);
    return {4'(code), 2'(mode), 4'(param), ip, junk};
  endfunction

  task automatic init_table();
    for (int s = 0; s < 5; s++)
      for (int c = 0; c < 5; c++) begin
        tr_next[s][c] = s; tr_cmd[s][c] = 0; tr_err[s][c] = 0;
      end
    tr_next[0][1] = 1; tr_cmd[0][1] = 1; tr_next[0][4] = 3; tr_cmd[0][4] = 5;
    tr_err[0][2] = 1;  tr_err[0][3] = 1;
    tr_next[1][2] = 2; tr_cmd[1][2] = 2; tr_next[1][3] = 0; tr_cmd[1][3] = 4; tr_err[1][4] = 1;
    tr_next[2][1] = 1; tr_cmd[2][1] = 3; tr_next[2][3] = 0; tr_cmd[2][3] = 4; tr_err[2][4] = 1;
    tr_next[3][2] = 4; tr_cmd[3][2] = 2; tr_next[3][3] = 0; tr_cmd[3][3] = 4; tr_err[3][1] = 1;
    tr_next[4][4] = 3; tr_cmd[4][4] = 3; tr_next[4][3] = 0; tr_cmd[4][3] = 4; tr_err[4][1] = 1;
  endtask

  task automatic model_reset();
    m_state = 0; m_valid = 0; m_cmd = 0; m_mode = 0; m_factor = 1; m_interp = 0; m_err = 0;
  endtask

  task automatic model_step(logic [15:0] ev, bit done, bit full, bit rdy);
    int code, mode, param;
    bit free;
    code  = int'(ev[15:12]);
    mode  = int'(ev[11:10]);
    param = int'(ev[9:6]);
    free  = !m_valid || rdy;
    m_err = 0;
    if (m_valid && rdy) m_valid = 0;
    if ((done && (m_state == 1 || m_state == 2)) || (full && (m_state == 3 || m_state == 4))) begin
      m_state = 0; m_valid = 0;
    end else if (code == 5) begin
      if (m_state >= 3 || mode == 3) m_err = 1;
      else begin
        m_mode   = mode;
        m_factor = (mode == 0 || param == 0) ? 1 : (param > 8 ? 8 : param);
        m_interp = (mode == 2) ? ev[5] : 1'b0;
      end
    end else if (code >= 1 && code <= 4) begin
      if (!free || tr_err[m_state][code]) m_err = 1;
      else if (tr_cmd[m_state][code] != 0) begin
        m_cmd   = tr_cmd[m_state][code];
        m_state = tr_next[m_state][code];
        m_valid = 1;
        if (m_cmd == 5) begin m_mode = 0; m_factor = 1; m_interp = 0; end
      end
    end else if (code != 0) m_err = 1;
  endtask

  task automatic applyStimulus(logic [15:0] ev, bit done, bit full, bit rdy);
    @(negedge clk);
    bus.i_input_event = ev;
    bus.i_play_done   = done;
    bus.i_rec_full    = full;
    bus.i_cmd_ready   = rdy;
    model_step(ev, done, full, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_input_event = '0; bus.i_play_done = 0; bus.i_rec_full = 0; bus.i_cmd_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== RESET_VEC) begin
      n_fail++; $display("[TB] FAIL reset_state: got %h want %h", obs, RESET_VEC);
    end
    rst = 1'b1;
    applyStimulus(16'h0000, 0, 0, 1);
    n_checks++;
    if (obs !== RESET_VEC) begin
      n_fail++; $display("[TB] FAIL reset_idle: got %h want %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_play_handshake();
    applyStimulus(mk_ev(1, 0, 0, 0), 0, 0, 1);
    n_checks++;
    if ({bus.o_state, bus.o_cmd_valid, bus.o_cmd, bus.o_err} !== {3'd1, 1'b1, 3'd1, 1'b0}) begin
      n_fail++; $display("[TB] FAIL play_issue: got %h want %h", obs, expv());
    end
    applyStimulus(16'h0000, 0, 0, 1);
    n_checks++;
    if (bus.o_cmd_valid !== 1'b0 || bus.o_state !== 3'd1) begin
      n_fail++; $display("[TB] FAIL play_accept: got %h want %h", obs, expv());
    end
    applyStimulus(mk_ev(3, 0, 0, 0), 0, 0, 1);
    n_checks++;
    if (obs !== expv() || bus.o_cmd !== 3'd4) begin
      n_fail++; $display("[TB] FAIL stop_issue: got %h want %h", obs, expv());
    end
    applyStimulus(16'h0000, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    applyStimulus(mk_ev(1, 0, 0, 0), 0, 0, 0);
    applyStimulus(mk_ev(2, 0, 0, 0), 0, 0, 0);
    n_checks++;
    if ({bus.o_state, bus.o_cmd_valid, bus.o_cmd, bus.o_err} !== {3'd1, 1'b1, 3'd1, 1'b1}) begin
      n_fail++; $display("[TB] FAIL busy_drop: got %h want %h", obs, expv());
    end
    applyStimulus(16'h0000, 0, 0, 0);
    n_checks++;
    if (bus.o_err !== 1'b0 || bus.o_cmd_valid !== 1'b1 || bus.o_cmd !== 3'd1) begin
      n_fail++; $display("[TB] FAIL busy_hold: got %h want %h", obs, expv());
    end
    // Accept and load a new command on the same edge
    applyStimulus(mk_ev(2, 0, 0, 0), 0, 0, 1);
    n_checks++;
    if (obs !== expv() || bus.o_cmd !== 3'd2 || bus.o_cmd_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL same_edge_load: got %h want %h", obs, expv());
    end
    applyStimulus(mk_ev(3, 0, 0, 0), 0, 0, 1);
    applyStimulus(16'h0000, 0, 0, 1);
  endtask

  task automatic test_speed();
    applyStimulus(mk_ev(5, 2, 12, 1), 0, 0, 1);
    n_checks++;
    if ({bus.o_speed_mode, bus.o_speed_factor, bus.o_interpol, bus.o_err} !== {2'b10, 4'd8, 1'b1, 1'b0}) begin
      n_fail++; $display("[TB] FAIL speed_slow_sat: got %h want %h", obs, expv());
    end
    applyStimulus(mk_ev(5, 0, 7, 1), 0, 0, 1);
    n_checks++;
    if ({bus.o_speed_mode, bus.o_speed_factor, bus.o_interpol} !== {2'b00, 4'd1, 1'b0}) begin
      n_fail++; $display("[TB] FAIL speed_normal: got %h want %h", obs, expv());
    end
    applyStimulus(mk_ev(5, 1, 0, 1), 0, 0, 1);
    n_checks++;
    if ({bus.o_speed_mode, bus.o_speed_factor, bus.o_interpol} !== {2'b01, 4'd1, 1'b0}) begin
      n_fail++; $display("[TB] FAIL speed_param0: got %h want %h", obs, expv());
    end
    applyStimulus(mk_ev(5, 3, 5, 1), 0, 0, 1);
    n_checks++;
    if ({bus.o_speed_mode, bus.o_speed_factor, bus.o_err} !== {2'b01, 4'd1, 1'b1}) begin
      n_fail++; $display("[TB] FAIL speed_mode3: got %h want %h", obs, expv());
    end
    applyStimulus(mk_ev(5, 1, 8, 0), 0, 0, 1);
    n_checks++;
    if (obs !== expv() || bus.o_speed_factor !== 4'd8) begin
      n_fail++; $display("[TB] FAIL speed_fast_max: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_record();
    applyStimulus(mk_ev(4, 0, 0, 0), 0, 0, 1);
    n_checks++;
    if ({bus.o_state, bus.o_cmd, bus.o_speed_mode, bus.o_speed_factor} !== {3'd3, 3'd5, 2'b00, 4'd1}) begin
      n_fail++; $display("[TB] FAIL start_rec: got %h want %h", obs, expv());
    end
    applyStimulus(mk_ev(5, 1, 3, 0), 0, 0, 1);
    n_checks++;
    if ({bus.o_err, bus.o_speed_mode, bus.o_speed_factor} !== {1'b1, 2'b00, 4'd1}) begin
      n_fail++; $display("[TB] FAIL rec_speed_err: got %h want %h", obs, expv());
    end
    applyStimulus(16'h0000, 0, 1, 0);
    n_checks++;
    if ({bus.o_state, bus.o_cmd_valid, bus.o_err} !== {3'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL rec_full: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_done_priority();
    applyStimulus(mk_ev(1, 0, 0, 0), 0, 0, 1);
    applyStimulus(16'h0000, 0, 0, 1);
    applyStimulus(mk_ev(2, 0, 0, 0), 1, 0, 1);
    n_checks++;
    if ({bus.o_state, bus.o_cmd_valid, bus.o_err} !== {3'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL done_priority: got %h want %h", obs, expv());
    end
    applyStimulus(16'h0000, 1, 1, 1);
    n_checks++;
    if (obs !== expv()) begin
      n_fail++; $display("[TB] FAIL done_in_idle: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_invalid_code();
    applyStimulus(mk_ev(9, 2, 4, 1), 0, 0, 1);
    n_checks++;
    if ({bus.o_state, bus.o_err} !== {3'd0, 1'b1} || obs !== expv()) begin
      n_fail++; $display("[TB] FAIL invalid_idle: got %h want %h", obs, expv());
    end
    applyStimulus(mk_ev(1, 0, 0, 0), 0, 0, 0);
    applyStimulus(mk_ev(9, 1, 2, 0), 0, 0, 0);
    n_checks++;
    if ({bus.o_state, bus.o_cmd_valid, bus.o_cmd, bus.o_err} !== {3'd1, 1'b1, 3'd1, 1'b1}) begin
      n_fail++; $display("[TB] FAIL invalid_play: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_reset_midhandshake();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs !== RESET_VEC) begin
      n_fail++; $display("[TB] FAIL reset_async: got %h want %h", obs, RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] ev;
    int code;
    for (int i = 0; i < 400; i++) begin
      code = $urandom_range(0, 7);
      if (code == 7) code = $urandom_range(6, 15);
      ev = {4'(code), 12'($urandom)};
      applyStimulus(ev, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 2) != 0);
      n_checks++;
      if (obs !== expv()) begin
        n_fail++; $display("[TB] FAIL random_%0d: ev %h got %h want %h", i, ev, obs, expv());
      end
    end
  endtask

  initial begin
    init_table();
    test_reset();
    test_play_handshake();
    test_back_to_back();
    test_speed();
    test_record();
    test_done_priority();
    test_invalid_code();
    test_reset_midhandshake();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
